// File: rtl/memory_writeback_if.sv
// EX/MEM input bundle and writeback/fetch outputs of the memory-writeback stage.
// The master side (the upstream stage) drives operations; the slave side is the stage itself.
interface memory_writeback_if #(
    parameter int unsigned PC_W = 10
);
    logic [3:0]      M_control;
    logic [1:0]      WB_control;
    logic            zero;
    logic [31:0]     ALU_out;
    logic [31:0]     data_write;
    logic [4:0]      WB_register;
    logic [PC_W-1:0] branch_target;
    logic            PC_sel;
    logic [PC_W-1:0] jump_address;
    logic [31:0]     busw;
    logic [4:0]      rw;
    logic            reg_write;

    modport master (
        output M_control, WB_control, zero, ALU_out, data_write, WB_register, branch_target,
        input  PC_sel, jump_address, busw, rw, reg_write
    );

    modport slave (
        input  M_control, WB_control, zero, ALU_out, data_write, WB_register, branch_target,
        output PC_sel, jump_address, busw, rw, reg_write
    );
endinterface

// File: rtl/memory_writeback.sv
// Two-stage memory/writeback pipeline: M holds the EX/MEM register and a read-first data
// memory; W holds the MEM/WB register feeding the register file.
module memory_writeback #(
    parameter int unsigned MEM_ADDR_W = 10,
    parameter int unsigned PC_W       = 10
) (
    input logic                clock,
    input logic                reset,
    memory_writeback_if.slave  bus
);
    // M stage
    logic            m_mem_read_q, m_mem_read_d;
    logic            m_mem_write_q, m_mem_write_d;
    logic            m_branch_q, m_branch_d;
    logic            m_bop_q, m_bop_d;
    logic            m_reg_write_q, m_reg_write_d;
    logic            m_mem_to_reg_q, m_mem_to_reg_d;
    logic            m_zero_q, m_zero_d;
    logic [31:0]     m_alu_out_q, m_alu_out_d;
    logic [31:0]     m_data_write_q, m_data_write_d;
    logic [4:0]      m_wb_register_q, m_wb_register_d;
    logic [PC_W-1:0] m_branch_target_q, m_branch_target_d;

    // W stage
    logic            w_reg_write_q, w_reg_write_d;
    logic            w_mem_to_reg_q, w_mem_to_reg_d;
    logic [31:0]     w_alu_out_q, w_alu_out_d;
    logic [31:0]     w_read_data_q, w_read_data_d;
    logic [4:0]      w_wb_register_q, w_wb_register_d;

    logic [31:0]           mem [2**MEM_ADDR_W];
    logic [MEM_ADDR_W-1:0] m_addr;
    logic                  mem_we;

    assign m_addr = m_alu_out_q[MEM_ADDR_W-1:0];
    // A store still sitting in M when reset arrives must not land in memory.
    assign mem_we = m_mem_write_q & ~reset;

    always_comb begin
        m_mem_read_d      = bus.M_control[3];
        m_mem_write_d     = bus.M_control[2];
        m_branch_d        = bus.M_control[1];
        m_bop_d           = bus.M_control[0];
        m_reg_write_d     = bus.WB_control[1];
        m_mem_to_reg_d    = bus.WB_control[0];
        m_zero_d          = bus.zero;
        m_alu_out_d       = bus.ALU_out;
        m_data_write_d    = bus.data_write;
        m_wb_register_d   = bus.WB_register;
        m_branch_target_d = bus.branch_target;
    end

    // Read-first: the array value seen here is the content before this cycle's write.
    always_comb begin
        w_reg_write_d   = m_reg_write_q;
        w_mem_to_reg_d  = m_mem_to_reg_q;
        w_alu_out_d     = m_alu_out_q;
        w_wb_register_d = m_wb_register_q;
        w_read_data_d   = m_mem_read_q ? mem[m_addr] : 32'h0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            m_mem_read_q      <= 1'b0;
            m_mem_write_q     <= 1'b0;
            m_branch_q        <= 1'b0;
            m_bop_q           <= 1'b0;
            m_reg_write_q     <= 1'b0;
            m_mem_to_reg_q    <= 1'b0;
            m_zero_q          <= 1'b0;
            m_alu_out_q       <= 32'h0;
            m_data_write_q    <= 32'h0;
            m_wb_register_q   <= 5'd0;
            m_branch_target_q <= '0;
            w_reg_write_q     <= 1'b0;
            w_mem_to_reg_q    <= 1'b0;
            w_alu_out_q       <= 32'h0;
            w_read_data_q     <= 32'h0;
            w_wb_register_q   <= 5'd0;
        end else begin
            m_mem_read_q      <= m_mem_read_d;
            m_mem_write_q     <= m_mem_write_d;
            m_branch_q        <= m_branch_d;
            m_bop_q           <= m_bop_d;
            m_reg_write_q     <= m_reg_write_d;
            m_mem_to_reg_q    <= m_mem_to_reg_d;
            m_zero_q          <= m_zero_d;
            m_alu_out_q       <= m_alu_out_d;
            m_data_write_q    <= m_data_write_d;
            m_wb_register_q   <= m_wb_register_d;
            m_branch_target_q <= m_branch_target_d;
            w_reg_write_q     <= w_reg_write_d;
            w_mem_to_reg_q    <= w_mem_to_reg_d;
            w_alu_out_q       <= w_alu_out_d;
            w_read_data_q     <= w_read_data_d;
            w_wb_register_q   <= w_wb_register_d;
        end
    end

    // Data memory is deliberately outside the reset domain.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[m_addr] <= m_data_write_q;
        end
    end

    always_comb begin
        bus.PC_sel       = m_branch_q & (m_bop_q ? m_zero_q : ~m_zero_q);
        bus.jump_address = m_branch_target_q;
        bus.busw         = w_mem_to_reg_q ? w_read_data_q : w_alu_out_q;
        bus.rw           = w_wb_register_q;
        bus.reg_write    = w_reg_write_q & (w_wb_register_q != 5'd0);
    end
endmodule

// File: tb/tb_memory_writeback.sv
// Directed bench for memory_writeback: stores/loads, ALU writeback, branches, r0, wrap,
// read-first collisions and reset during a store.
module tb_memory_writeback;
    logic clock;
    logic reset;
    int   n_checks;
    int   n_errors;

    memory_writeback_if #(.PC_W(10)) bus ();

    memory_writeback #(
        .MEM_ADDR_W(10),
        .PC_W      (10)
    ) u_dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [3:0] mc, input logic [1:0] wb, input logic z,
                         input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] wbr,
                         input logic [9:0] bt);
        bus.M_control     = mc;
        bus.WB_control    = wb;
        bus.zero          = z;
        bus.ALU_out       = alu;
        bus.data_write    = wd;
        bus.WB_register   = wbr;
        bus.branch_target = bt;
    endtask

    task automatic nop();
        drive(4'b0000, 2'b00, 1'b0, 32'h0, 32'h0, 5'd0, 10'h0);
    endtask

    // Advance one rising edge and sample just after it.
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic check_wb(input string tag, input logic [31:0] busw, input logic [4:0] rw,
                            input logic we);
        check_val({tag, "_busw"}, bus.busw, busw);
        check_val({tag, "_rw"}, {27'h0, bus.rw}, {27'h0, rw});
        check_val({tag, "_we"}, {31'h0, bus.reg_write}, {31'h0, we});
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        nop();
        cyc();
        cyc();
        check_val("rst_pc_sel", {31'h0, bus.PC_sel}, 32'h0);
        check_val("rst_jump", {22'h0, bus.jump_address}, 32'h0);
        check_wb("rst", 32'h0, 5'd0, 1'b0);

        // ALU writeback right out of reset
        reset = 1'b0;
        drive(4'b0000, 2'b10, 1'b0, 32'h12, 32'h0, 5'd7, 10'h0);
        cyc();
        check_val("first_edge_we", {31'h0, bus.reg_write}, 32'h0);
        nop();
        cyc();
        check_wb("alu_wb", 32'h12, 5'd7, 1'b1);

        // Store then load same word
        drive(4'b0100, 2'b00, 1'b0, 32'd5, 32'hDEADBEEF, 5'd0, 10'h0);
        cyc();
        drive(4'b1000, 2'b11, 1'b0, 32'd5, 32'h0, 5'd3, 10'h0);
        cyc();
        nop();
        cyc();
        check_wb("st_ld", 32'hDEADBEEF, 5'd3, 1'b1);

        // Branches
        drive(4'b0011, 2'b00, 1'b1, 32'h0, 32'h0, 5'd0, 10'h2A);
        cyc();
        check_val("beq_taken", {31'h0, bus.PC_sel}, 32'h1);
        check_val("beq_target", {22'h0, bus.jump_address}, 32'h2A);
        nop();
        cyc();
        check_val("beq_one_cycle", {31'h0, bus.PC_sel}, 32'h0);
        drive(4'b0011, 2'b00, 1'b0, 32'h0, 32'h0, 5'd0, 10'h15);
        cyc();
        check_val("beq_not_taken", {31'h0, bus.PC_sel}, 32'h0);
        check_val("jump_indep", {22'h0, bus.jump_address}, 32'h15);
        drive(4'b0010, 2'b00, 1'b0, 32'h0, 32'h0, 5'd0, 10'h3);
        cyc();
        check_val("bne_taken", {31'h0, bus.PC_sel}, 32'h1);
        drive(4'b0010, 2'b00, 1'b1, 32'h0, 32'h0, 5'd0, 10'h3);
        cyc();
        check_val("bne_not_taken", {31'h0, bus.PC_sel}, 32'h0);

        // Write to r0 suppressed
        drive(4'b0000, 2'b10, 1'b0, 32'h33, 32'h0, 5'd0, 10'h0);
        cyc();
        nop();
        cyc();
        check_wb("r0", 32'h33, 5'd0, 1'b0);

        // Address wrap: 0x405 aliases 0x005
        drive(4'b0100, 2'b00, 1'b0, 32'h405, 32'hCAFEF00D, 5'd0, 10'h0);
        cyc();
        drive(4'b1000, 2'b11, 1'b0, 32'h005, 32'h0, 5'd4, 10'h0);
        cyc();
        nop();
        cyc();
        check_wb("wrap", 32'hCAFEF00D, 5'd4, 1'b1);

        // Read-first collision at word 9
        drive(4'b0100, 2'b00, 1'b0, 32'd9, 32'h1, 5'd0, 10'h0);
        cyc();
        drive(4'b1100, 2'b11, 1'b0, 32'd9, 32'h2, 5'd5, 10'h0);
        cyc();
        drive(4'b1000, 2'b11, 1'b0, 32'd9, 32'h0, 5'd6, 10'h0);
        cyc();
        check_wb("rw_old", 32'h1, 5'd5, 1'b1);
        nop();
        cyc();
        check_wb("rw_new", 32'h2, 5'd6, 1'b1);

        // Reset with a store (and taken branch) held in M
        drive(4'b0100, 2'b00, 1'b0, 32'd20, 32'h55, 5'd0, 10'h0);
        cyc();
        nop();
        cyc();
        drive(4'b0110, 2'b10, 1'b0, 32'd20, 32'hBAD, 5'd9, 10'h3F);
        cyc();
        check_val("pre_rst_pc_sel", {31'h0, bus.PC_sel}, 32'h1);
        reset = 1'b1;
        nop();
        cyc();
        check_val("mid_rst_pc_sel", {31'h0, bus.PC_sel}, 32'h0);
        check_val("mid_rst_jump", {22'h0, bus.jump_address}, 32'h0);
        check_wb("mid_rst", 32'h0, 5'd0, 1'b0);
        reset = 1'b0;
        drive(4'b1000, 2'b11, 1'b0, 32'd20, 32'h0, 5'd2, 10'h0);
        cyc();
        nop();
        cyc();
        check_wb("mem_kept", 32'h55, 5'd2, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
